led_addr_gen: RTL and testbench
===============================

LED_ADDR_GEN -- requirements
Module: led_addr_gen

Interface
REQ-001 Parameter: PRESCALE, default 50000000, clk cycles per address step (0.25 s at 200 MHz); legal range 1..2^26-1.
REQ-002 Port: clk  input  1  200 MHz clock; the only clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle pulse; start or resume stepping.
REQ-005 Port: stop  input  1  one-cycle pulse; pause, or return to idle if already paused.
REQ-006 Port: dir  input  1  step direction, 0 = up (addr+1), 1 = down (addr-1).
REQ-007 Port: rom_en  output  1  drives the pattern ROM enable; ROM output is forced to 0 while low.
REQ-008 Port: addr  output  12  pattern ROM word address.
REQ-009 Port: step  output  1  one-cycle pulse, asserted in the first cycle a new addr value is presented.
REQ-010 Port: wrap  output  1  one-cycle pulse, coincident with step, when addr crosses an end of the address space.
REQ-011 Port: busy  output  1  high in RUN and PAUSE.

Function
REQ-012 States: IDLE, RUN, PAUSE; state register is one-hot or binary, implementer's choice.
REQ-013 Transitions:
- IDLE + start -> RUN; addr loads 0 if dir=0, 4095 if dir=1; prescaler cleared.
- RUN + stop -> PAUSE.
- PAUSE + start -> RUN; addr and prescaler are kept.
- PAUSE + stop -> IDLE.
REQ-014 start and stop asserted in the same cycle: stop wins.
REQ-015 start in RUN and stop in IDLE are ignored.
REQ-016 rom_en = busy, so the ROM holds its last pattern in PAUSE and is dark in IDLE.
REQ-017 In IDLE, addr holds its last value.
REQ-018 Prescaler:
- counts 0..PRESCALE-1 in RUN only;
- holds in PAUSE;
- cleared in IDLE.
REQ-019 Step event: the RUN cycle in which the prescaler equals PRESCALE-1. On it, the prescaler returns to 0 and addr updates, visible the next cycle, together with step=1.
REQ-020 Step timing: first step occurs PRESCALE cycles after entering RUN from IDLE; PRESCALE=1 steps every RUN cycle.
REQ-021 dir is sampled at every step event, so a direction change takes effect on the next step.
REQ-022 Wrap mode: 4095 -> 0 going up and 0 -> 4095 going down, both with wrap=1 (12-bit modulo arithmetic).
REQ-023 A stop in the same cycle as a step event: the step completes (addr updates), then state is PAUSE.
REQ-024 step and wrap are 0 in every cycle other than those defined above.

Reset
REQ-025 rst is synchronous and active-high and overrides all other inputs; next-cycle values:
- state = IDLE;
- addr = 0, prescaler = 0;
- rom_en = 0, step = 0, wrap = 0, busy = 0.
REQ-026 rst asserted mid-RUN aborts immediately with no step or wrap pulse.

Configuration
REQ-027 Macro LED_ADDR_GEN_BOUNCE_EN selects the end-of-range behaviour.
REQ-028 Without LED_ADDR_GEN_BOUNCE_EN: wrap mode per REQ-022; dir is honoured at every step.
REQ-029 With LED_ADDR_GEN_BOUNCE_EN, an internal direction register replaces dir:
- it is loaded from dir on IDLE -> RUN; dir is ignored otherwise;
- at 4095 going up, the next addr is 4094 and direction flips to down; at 0 going down, the next addr is 1 and direction flips to up;
- wrap=1 on each reversal step.

Verification (PRESCALE=4 unless stated)
REQ-030 Reset then start with dir=0: addr=0 and rom_en=1 from the next cycle; step plus addr=1 appear 4 cycles after RUN entry, addr=2 four cycles later.
REQ-031 Up-wrap: run dir=0 to addr=4095, one more step -> addr=0 with step=1 and wrap=1 in the same cycle. Repeat with dir=1 from 0 -> addr=4095, wrap=1.
REQ-032 Pause/resume: stop at prescaler=2 -> busy=1, rom_en=1, addr frozen for 20 cycles. Then:
- start -> next step 2 cycles later;
- stop, stop -> IDLE, rom_en=0.
REQ-033 Start and stop in the same cycle while in PAUSE -> IDLE. stop coincident with a step event -> addr advances once, then PAUSE.
REQ-034 rst during RUN at addr=37 -> next cycle addr=0, busy=0, step=0. PRESCALE=1: addr increments every RUN cycle.
REQ-035 With LED_ADDR_GEN_BOUNCE_EN: sequence 4094, 4095, 4094 with wrap=1 on the 4095 -> 4094 step; toggling dir during RUN has no effect.

Source files
------------

// File: rtl/led_addr_gen_if.sv
// Control and status bundle of the LED pattern ROM address generator.
// The master drives start/stop/dir and the generator (slave) returns the ROM address and status.
interface led_addr_gen_if;
   logic        start;
   logic        stop;
   logic        dir;
   logic        rom_en;
   logic [11:0] addr;
   logic        step;
   logic        wrap;
   logic        busy;

   modport master (
      output start, stop, dir,
      input  rom_en, addr, step, wrap, busy
   );

   modport slave (
      input  start, stop, dir,
      output rom_en, addr, step, wrap, busy
   );
endinterface

// File: rtl/led_addr_gen.sv
// LED pattern ROM address generator: IDLE/RUN/PAUSE stepper with a PRESCALE-cycle step interval.
// Define LED_ADDR_GEN_BOUNCE_EN to reverse at the ends of the address space instead of wrapping.
module led_addr_gen #(
   parameter int unsigned PRESCALE = 50000000
) (
   input  logic           clk,
   input  logic           rst,
   led_addr_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [25:0] PRESC_LAST = 26'(PRESCALE - 32'd1);
   localparam logic [11:0] ADDR_MAX   = 12'hFFF;

   state_t      state_q, state_d;
   logic [25:0] presc_q, presc_d;
   logic [11:0] addr_q, addr_d;
   logic        step_q, step_d;
   logic        wrap_q, wrap_d;
   logic        busy_q, busy_d;
   logic        step_evt_s;
   logic        start_run_s;
   logic        dir_eff_s;
`ifdef LED_ADDR_GEN_BOUNCE_EN
   logic        dir_q, dir_d;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; stop takes priority over start
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start && !bus.stop) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
            end else if (bus.start) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath logic: prescaler, address stepping and end-of-range handling
   always_comb begin
      step_evt_s  = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
      start_run_s = (state_q == ST_IDLE) && bus.start && !bus.stop;
      presc_d     = presc_q;
      addr_d      = addr_q;
      step_d      = 1'b0;
      wrap_d      = 1'b0;
      busy_d      = (state_d != ST_IDLE);
`ifdef LED_ADDR_GEN_BOUNCE_EN
      dir_d       = dir_q;
      dir_eff_s   = dir_q;
`else
      dir_eff_s   = bus.dir;
`endif
      if (start_run_s) begin
         presc_d = 26'd0;
         addr_d  = bus.dir ? ADDR_MAX : 12'd0;
`ifdef LED_ADDR_GEN_BOUNCE_EN
         dir_d   = bus.dir;
`endif
      end else if (state_q == ST_RUN) begin
         if (step_evt_s) begin
            presc_d = 26'd0;
            step_d  = 1'b1;
            if (!dir_eff_s) begin
               if (addr_q == ADDR_MAX) begin
                  wrap_d = 1'b1;
`ifdef LED_ADDR_GEN_BOUNCE_EN
                  addr_d = 12'hFFE;
                  dir_d  = 1'b1;
`else
                  addr_d = 12'd0;
`endif
               end else begin
                  addr_d = addr_q + 12'd1;
               end
            end else begin
               if (addr_q == 12'd0) begin
                  wrap_d = 1'b1;
`ifdef LED_ADDR_GEN_BOUNCE_EN
                  addr_d = 12'd1;
                  dir_d  = 1'b0;
`else
                  addr_d = ADDR_MAX;
`endif
               end else begin
                  addr_d = addr_q - 12'd1;
               end
            end
         end else begin
            presc_d = presc_q + 26'd1;
         end
      end else if (state_q == ST_IDLE) begin
         presc_d = 26'd0;
      end else begin
         presc_d = presc_q;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= 26'd0;
         addr_q  <= 12'd0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef LED_ADDR_GEN_BOUNCE_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         presc_q <= presc_d;
         addr_q  <= addr_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
         busy_q  <= busy_d;
`ifdef LED_ADDR_GEN_BOUNCE_EN
         dir_q   <= dir_d;
`endif
      end
   end

   assign bus.addr   = addr_q;
   assign bus.step   = step_q;
   assign bus.wrap   = wrap_q;
   assign bus.busy   = busy_q;
   assign bus.rom_en = busy_q;

endmodule

// File: tb/tb_led_addr_gen.sv
// Directed self-checking bench for led_addr_gen (PRESCALE=4 main instance, PRESCALE=1 second instance).
// Honours LED_ADDR_GEN_BOUNCE_EN to select the end-of-range expectations.
module tb_led_addr_gen;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   led_addr_gen_if bi ();
   led_addr_gen_if b1 ();

   led_addr_gen #(.PRESCALE(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bi.slave)
   );

   led_addr_gen #(.PRESCALE(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      rst = 1'b1;
      bi.start = 1'b0; bi.stop = 1'b0; bi.dir = 1'b0;
      b1.start = 1'b0; b1.stop = 1'b0; b1.dir = 1'b0;
      tick(2);
      chk("rst_addr",   bi.addr,   12'd0);
      chk("rst_busy",   bi.busy,   12'd0);
      chk("rst_rom_en", bi.rom_en, 12'd0);
      chk("rst_step",   bi.step,   12'd0);
      chk("rst_wrap",   bi.wrap,   12'd0);
      chk("rst_busy1",  b1.busy,   12'd0);
      rst = 1'b0;
      tick(1);

      // Start from IDLE going up: first step after 4 RUN cycles
      bi.start = 1'b1; tick(1); bi.start = 1'b0;
      chk("entry_addr",   bi.addr,   12'd0);
      chk("entry_rom_en", bi.rom_en, 12'd1);
      chk("entry_step",   bi.step,   12'd0);
      tick(3);
      chk("pre_step1",    bi.step,   12'd0);
      tick(1);
      chk("step1_step",   bi.step,   12'd1);
      chk("step1_addr",   bi.addr,   12'd1);
      chk("step1_wrap",   bi.wrap,   12'd0);
      tick(1);
      chk("step1_pulse",  bi.step,   12'd0);
      tick(3);
      chk("step2_step",   bi.step,   12'd1);
      chk("step2_addr",   bi.addr,   12'd2);

      // Pause with prescaler at 2, hold, then resume
      tick(2);
      bi.stop = 1'b1; tick(1); bi.stop = 1'b0;
      chk("pause_busy",   bi.busy,   12'd1);
      chk("pause_rom_en", bi.rom_en, 12'd1);
      chk("pause_addr",   bi.addr,   12'd2);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("pause_hold_addr", bi.addr, 12'd2);
         chk("pause_hold_step", bi.step, 12'd0);
      end
      bi.start = 1'b1; tick(1); bi.start = 1'b0;
      chk("resume_wait",  bi.step,   12'd0);
      tick(1);
      chk("resume_step",  bi.step,   12'd1);
      chk("resume_addr",  bi.addr,   12'd3);
      bi.stop = 1'b1; tick(1); bi.stop = 1'b0;
      chk("stop1_busy",   bi.busy,   12'd1);
      bi.stop = 1'b1; tick(1); bi.stop = 1'b0;
      chk("stop2_busy",   bi.busy,   12'd0);
      chk("stop2_rom_en", bi.rom_en, 12'd0);
      tick(5);
      chk("idle_hold",    bi.addr,   12'd3);
      bi.start = 1'b1; bi.stop = 1'b1; tick(1); bi.start = 1'b0; bi.stop = 1'b0;
      chk("idle_ss_busy", bi.busy,   12'd0);

`ifndef LED_ADDR_GEN_BOUNCE_EN
      // Load 4095 going down, then step up across the top, then down across zero
      bi.dir = 1'b1; bi.start = 1'b1; tick(1); bi.start = 1'b0;
      chk("load_top",     bi.addr,   12'd4095);
      bi.dir = 1'b0; tick(4);
      chk("upwrap_addr",  bi.addr,   12'd0);
      chk("upwrap_step",  bi.step,   12'd1);
      chk("upwrap_wrap",  bi.wrap,   12'd1);
      bi.dir = 1'b1; tick(4);
      chk("dnwrap_addr",  bi.addr,   12'd4095);
      chk("dnwrap_step",  bi.step,   12'd1);
      chk("dnwrap_wrap",  bi.wrap,   12'd1);
      tick(4);
      chk("down_addr",    bi.addr,   12'd4094);
      chk("down_wrap",    bi.wrap,   12'd0);
`else
      // Bounce: dir only sampled on IDLE->RUN; reversal at both ends
      bi.dir = 1'b1; bi.start = 1'b1; tick(1); bi.start = 1'b0;
      chk("b_load_top",   bi.addr,   12'd4095);
      bi.dir = 1'b0; tick(4);
      chk("b_dir_ign",    bi.addr,   12'd4094);
      chk("b_dir_wrap",   bi.wrap,   12'd0);
      bi.stop = 1'b1; tick(1); tick(1); bi.stop = 1'b0;
      bi.dir = 1'b0; bi.start = 1'b1; tick(1); bi.start = 1'b0;
      chk("b_load_zero",  bi.addr,   12'd0);
      bi.dir = 1'b1;
      tick(4 * 4094);
      chk("b_4094",       bi.addr,   12'd4094);
      tick(4);
      chk("b_4095",       bi.addr,   12'd4095);
      chk("b_4095_wrap",  bi.wrap,   12'd0);
      tick(4);
      chk("b_rev_addr",   bi.addr,   12'd4094);
      chk("b_rev_wrap",   bi.wrap,   12'd1);
      chk("b_rev_step",   bi.step,   12'd1);
      tick(4);
      chk("b_4093",       bi.addr,   12'd4093);
      tick(4 * 4093);
      chk("b_zero",       bi.addr,   12'd0);
      chk("b_zero_wrap",  bi.wrap,   12'd0);
      tick(4);
      chk("b_rev0_addr",  bi.addr,   12'd1);
      chk("b_rev0_wrap",  bi.wrap,   12'd1);
      tick(4);
      chk("b_after_rev0", bi.addr,   12'd2);
`endif
      bi.stop = 1'b1; tick(1); tick(1); bi.stop = 1'b0;
      chk("to_idle_busy", bi.busy,   12'd0);

      // stop coincident with a step event: step completes, then PAUSE
      bi.dir = 1'b0; bi.start = 1'b1; tick(1); bi.start = 1'b0;
      tick(3);
      bi.stop = 1'b1; tick(1); bi.stop = 1'b0;
      chk("stopstep_addr", bi.addr,  12'd1);
      chk("stopstep_step", bi.step,  12'd1);
      chk("stopstep_busy", bi.busy,  12'd1);
      tick(4);
      chk("stopstep_hold", bi.addr,  12'd1);
      chk("stopstep_nost", bi.step,  12'd0);
      bi.start = 1'b1; bi.stop = 1'b1; tick(1); bi.start = 1'b0; bi.stop = 1'b0;
      chk("pause_ss_busy", bi.busy,  12'd0);
      chk("pause_ss_rom",  bi.rom_en, 12'd0);

      // Reset during RUN at addr 37, in the cycle of a step event
      bi.start = 1'b1; tick(1); bi.start = 1'b0;
      tick(4 * 37);
      chk("run37_addr",   bi.addr,   12'd37);
      tick(3);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk("mrst_addr",    bi.addr,   12'd0);
      chk("mrst_busy",    bi.busy,   12'd0);
      chk("mrst_step",    bi.step,   12'd0);
      chk("mrst_wrap",    bi.wrap,   12'd0);
      chk("mrst_rom_en",  bi.rom_en, 12'd0);

      // PRESCALE=1: a step on every RUN cycle
      b1.start = 1'b1; tick(1); b1.start = 1'b0;
      chk("p1_entry",     b1.addr,   12'd0);
      chk("p1_busy",      b1.busy,   12'd1);
      chk("p1_entry_st",  b1.step,   12'd0);
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         chk("p1_addr",   b1.addr,   12'(k));
         chk("p1_step",   b1.step,   12'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
